// File: rtl/sram_arb_pkg.sv
// Shared constants for the two-requester SRAM arbiter.
//   ST_*  : 2-bit FSM state encodings (11 is illegal and recovers to IDLE)
//   RQ0/1 : requester ids as carried in the transaction register
package sram_arb_pkg;
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCESS = 2'b01;
  localparam logic [1:0] ST_RESP   = 2'b10;

  localparam logic RQ0 = 1'b0;
  localparam logic RQ1 = 1'b1;
endpackage

// File: rtl/sram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the SRAM.
//   rq0_* / rq1_* : req/we/addr/wdata in, ack/rdata out (one-cycle ack pulse)
//   mem_*         : SRAM cs/wr_en/addr/wr_data out, rd_data in (combinational)
//   busy          : arbiter not idle
// Modports: slave = arbiter view, master = requesters + SRAM view.
interface sram_arbiter_if #(
  parameter int N = 4,
  parameter int W = 4,
  parameter int A = $clog2(N)
);
  logic         rq0_req, rq0_we, rq0_ack;
  logic [A-1:0] rq0_addr;
  logic [W-1:0] rq0_wdata, rq0_rdata;
  logic         rq1_req, rq1_we, rq1_ack;
  logic [A-1:0] rq1_addr;
  logic [W-1:0] rq1_wdata, rq1_rdata;
  logic         mem_cs, mem_wr_en;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_wr_data, mem_rd_data;
  logic         busy;

  modport slave (
    input  rq0_req, rq0_we, rq0_addr, rq0_wdata,
    input  rq1_req, rq1_we, rq1_addr, rq1_wdata,
    input  mem_rd_data,
    output rq0_ack, rq0_rdata, rq1_ack, rq1_rdata,
    output mem_cs, mem_wr_en, mem_addr, mem_wr_data, busy
  );

  modport master (
    output rq0_req, rq0_we, rq0_addr, rq0_wdata,
    output rq1_req, rq1_we, rq1_addr, rq1_wdata,
    output mem_rd_data,
    input  rq0_ack, rq0_rdata, rq1_ack, rq1_rdata,
    input  mem_cs, mem_wr_en, mem_addr, mem_wr_data, busy
  );
endinterface

// File: rtl/sram_rr_pick.sv
// Combinational winner select for two requesters.
//   req[1:0]  : pending requests
//   prio      : id favoured when both request (round-robin pointer)
//   gnt_valid : some request is pending
//   gnt_id    : winning requester id
// Build option SRAM_ARB_FIXED_PRIO_EN: requester 0 always wins a tie and
// prio is ignored.
module sram_rr_pick
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic       gnt_valid,
  output logic       gnt_id
);
  always_comb begin
    gnt_valid = |req;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    gnt_id = req[0] ? RQ0 : RQ1;
`else
    if (req == 2'b11) gnt_id = prio;
    else              gnt_id = req[1] ? RQ1 : RQ0;
`endif
  end
endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter/sequencer for a single-port SRAM.
// IDLE -> ACCESS -> RESP -> IDLE; ack arrives two cycles after the grant.
//   clk  : system clock (posedge)
//   rst  : synchronous active-high reset
//   bus  : sram_arbiter_if.slave (requester handshakes, SRAM pins, busy)
// Build option SRAM_ARB_FIXED_PRIO_EN: fixed priority to requester 0,
// no round-robin pointer.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 4,
  parameter int A = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  sram_arbiter_if.slave  bus
);
  typedef struct packed {
    logic         id;
    logic         we;
    logic [A-1:0] addr;
    logic [W-1:0] wdata;
  } txn_t;

  logic [1:0] state;
  txn_t       txn, req_txn;
  logic [W-1:0] rdata_q;
  logic       prio, gnt_valid, gnt_id;
  logic       in_access, ack_ok, ack0, ack1;

  sram_rr_pick u_pick (
    .req       ({bus.rq1_req, bus.rq0_req}),
    .prio      (prio),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Payload of the current winner, latched only at grant.
  always_comb begin
    req_txn.id    = gnt_id;
    req_txn.we    = gnt_id ? bus.rq1_we    : bus.rq0_we;
    req_txn.addr  = gnt_id ? bus.rq1_addr  : bus.rq0_addr;
    req_txn.wdata = gnt_id ? bus.rq1_wdata : bus.rq0_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      txn     <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (gnt_valid) begin
          txn   <= req_txn;
          state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (!txn.we) rdata_q <= bus.mem_rd_data;
          state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign prio = RQ0;
`else
  // Loser of each grant is favoured next time.
  always_ff @(posedge clk) begin
    if (rst)                              prio <= RQ0;
    else if (state == ST_IDLE && gnt_valid) prio <= ~gnt_id;
  end
`endif

  // SRAM pins follow the state alone (not rst), so a write in an ACCESS
  // cycle that coincides with reset still lands.
  assign in_access       = (state == ST_ACCESS);
  assign bus.mem_cs      = in_access;
  assign bus.mem_wr_en   = in_access & txn.we;
  assign bus.mem_addr    = in_access ? txn.addr  : '0;
  assign bus.mem_wr_data = in_access ? txn.wdata : '0;

  // Reset in RESP suppresses the ack: the transaction is dropped.
  assign ack_ok        = (state == ST_RESP) && !rst;
  assign ack0          = ack_ok && (txn.id == RQ0);
  assign ack1          = ack_ok && (txn.id == RQ1);
  assign bus.rq0_ack   = ack0;
  assign bus.rq1_ack   = ack1;
  assign bus.rq0_rdata = (ack0 && !txn.we) ? rdata_q : '0;
  assign bus.rq1_rdata = (ack1 && !txn.we) ? rdata_q : '0;
  assign bus.busy      = (state != ST_IDLE);
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios with literal expectations plus a
// transaction-schedule model checked against the DUT pins every cycle.
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic init_mem;
  int   cyc = 0;
  int   nchecks = 0;
  int   nfail = 0;
  int   cs_cnt = 0;
  int   ack_ids[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_arbiter_if bus ();
  sram_arbiter dut (.clk(clk), .rst(rst), .bus(bus.slave));

  function automatic int pre(input int i);
    return 3 * (i + 1);  // 3,6,9,C
  endfunction

  // Bench SRAM: synchronous write, combinational read.
  logic [3:0] sram [4];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 4; i++) sram[i] <= 4'(pre(i));
    end else if (bus.mem_cs && bus.mem_wr_en) begin
      sram[bus.mem_addr] <= bus.mem_wr_data;
    end
  end
  assign bus.mem_rd_data = sram[bus.mem_addr];

  task automatic chk(input string nm, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // ---------------- schedule model ----------------
  // A grant at cycle t books cycle t+1 for the SRAM access and t+2 for the ack.
  int   m_acc, m_ack, m_prio, m_id, m_addr, m_wd, m_rd;
  logic m_we;
  int   mmem [4];

  initial begin
    int  w;
    logic e_busy, e_cs, e_ack0, e_ack1;
    m_acc = -1; m_ack = -1; m_prio = 0; m_id = 0; m_we = 0;
    m_addr = 0; m_wd = 0; m_rd = 0;
    for (int i = 0; i < 4; i++) mmem[i] = pre(i);
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_busy = (cyc == m_acc) || (cyc == m_ack);
      e_cs   = (cyc == m_acc);
      e_ack0 = (cyc == m_ack) && !rst && (m_id == 0);
      e_ack1 = (cyc == m_ack) && !rst && (m_id == 1);
      chk("busy",        int'(bus.busy),        int'(e_busy));
      chk("mem_cs",      int'(bus.mem_cs),      int'(e_cs));
      chk("mem_wr_en",   int'(bus.mem_wr_en),   int'(e_cs && m_we));
      chk("mem_addr",    int'(bus.mem_addr),    e_cs ? m_addr : 0);
      chk("mem_wr_data", int'(bus.mem_wr_data), e_cs ? m_wd : 0);
      chk("rq0_ack",     int'(bus.rq0_ack),     int'(e_ack0));
      chk("rq1_ack",     int'(bus.rq1_ack),     int'(e_ack1));
      chk("rq0_rdata",   int'(bus.rq0_rdata),   (e_ack0 && !m_we) ? m_rd : 0);
      chk("rq1_rdata",   int'(bus.rq1_rdata),   (e_ack1 && !m_we) ? m_rd : 0);
      if (bus.mem_cs) cs_cnt++;
      if (bus.rq0_ack) ack_ids.push_back(0);
      if (bus.rq1_ack) ack_ids.push_back(1);
      // Effects of the coming edge.
      if (cyc == m_acc) begin
        if (m_we) mmem[m_addr] = m_wd;
        else      m_rd = mmem[m_addr];
      end
      if (rst) begin
        m_acc = -1; m_ack = -1; m_prio = 0;
      end else if (!e_busy && (bus.rq0_req || bus.rq1_req)) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
        w = bus.rq0_req ? 0 : 1;
`else
        w = (bus.rq0_req && bus.rq1_req) ? m_prio : (bus.rq1_req ? 1 : 0);
`endif
        m_prio = 1 - w;
        m_id   = w;
        m_we   = w ? bus.rq1_we : bus.rq0_we;
        m_addr = w ? int'(bus.rq1_addr)  : int'(bus.rq0_addr);
        m_wd   = w ? int'(bus.rq1_wdata) : int'(bus.rq0_wdata);
        m_acc  = cyc + 1;
        m_ack  = cyc + 2;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input int id, input logic r, input logic we, input int addr, input int wd);
    if (id == 0) begin
      bus.rq0_req = r; bus.rq0_we = we; bus.rq0_addr = 2'(addr); bus.rq0_wdata = 4'(wd);
    end else begin
      bus.rq1_req = r; bus.rq1_we = we; bus.rq1_addr = 2'(addr); bus.rq1_wdata = 4'(wd);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst busy",   int'(bus.busy),    0);
    chk("rst ack0",   int'(bus.rq0_ack), 0);
    chk("rst ack1",   int'(bus.rq1_ack), 0);
    chk("rst mem_cs", int'(bus.mem_cs),  0);
    step();
  endtask

  // Single transaction; returns ack delay from the request cycle and rdata.
  task automatic do_txn(input int id, input logic we, input int addr, input int wd,
                        output int dly, output int rd);
    int k;
    bit done;
    drive(id, 1'b1, we, addr, wd);
    k = cyc; dly = -1; rd = -1; done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if ((id == 0 && bus.rq0_ack) || (id == 1 && bus.rq1_ack)) begin
        done = 1; dly = cyc - k;
        rd = id ? int'(bus.rq1_rdata) : int'(bus.rq0_rdata);
      end
    end
    step();
    drive(id, 1'b0, we, addr, wd);
  endtask

  // Both requesters raise together; each drops after its own ack.
  task automatic do_pair(input int a0, input int a1,
                         output int c0, output int c1, output int r0, output int r1);
    int k;
    bit d0, d1;
    drive(0, 1'b1, 1'b0, a0, 0);
    drive(1, 1'b1, 1'b0, a1, 0);
    k = cyc; d0 = 0; d1 = 0; c0 = -1; c1 = -1; r0 = -1; r1 = -1;
    for (int i = 0; i < 20 && !(d0 && d1); i++) begin
      @(negedge clk);
      if (bus.rq0_ack) begin d0 = 1; c0 = cyc - k; r0 = int'(bus.rq0_rdata); end
      if (bus.rq1_ack) begin d1 = 1; c1 = cyc - k; r1 = int'(bus.rq1_rdata); end
      step();
      if (d0) bus.rq0_req = 1'b0;
      if (d1) bus.rq1_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, r, c0, c1, r0, r1, k, n0, cs0, a1, a2, rd2;
    int exp_ids [4];
    bit done;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    exp_ids = '{0, 0, 0, 0};
`else
    exp_ids = '{0, 1, 0, 1};
`endif
    rst = 1'b1; init_mem = 1'b1;
    drive(0, 1'b0, 1'b0, 0, 0);
    drive(1, 1'b0, 1'b0, 0, 0);
    step();
    init_mem = 1'b0;
    do_reset();

    // Write then read back on requester 0.
    cs0 = cs_cnt;
    do_txn(0, 1'b1, 2, 10, d, r);
    chk("t1 wr latency", d, 2);
    chk("t1 wr rdata", r, 0);
    do_txn(0, 1'b0, 2, 0, d, r);
    chk("t1 rd latency", d, 2);
    chk("t1 rd rdata", r, 10);
    chk("t1 cs cycles", cs_cnt - cs0, 2);

    // Simultaneous reads after reset: rq0 first, rq1 three cycles later.
    do_reset();
    do_pair(1, 3, c0, c1, r0, r1);
    chk("t2 ack0 cyc", c0, 2);
    chk("t2 ack1 cyc", c1, 5);
    chk("t2 rdata0", r0, 6);
    chk("t2 rdata1", r1, 12);

    // Continuous contention for 12 cycles.
    step();
    n0 = ack_ids.size();
    drive(0, 1'b1, 1'b0, 0, 0);
    drive(1, 1'b1, 1'b0, 3, 0);
    repeat (12) step();
    drive(0, 1'b0, 1'b0, 0, 0);
    drive(1, 1'b0, 1'b0, 0, 0);
    repeat (4) step();
    chk("t3 ack count", ack_ids.size() - n0, 4);
    for (int i = 0; i < 4; i++)
      chk("t3 ack order", (n0 + i < ack_ids.size()) ? ack_ids[n0 + i] : -1, exp_ids[i]);

    // Payload changes and req drop during ACCESS do not affect the txn.
    k = cyc;
    drive(1, 1'b1, 1'b1, 0, 5);
    step();
    drive(1, 1'b0, 1'b1, 1, 15);
    done = 0; d = -1;
    for (int i = 0; i < 6 && !done; i++) begin
      @(negedge clk);
      if (bus.rq1_ack) begin done = 1; d = cyc - k; end
    end
    step(); step();
    chk("t4 ack cyc", d, 2);
    chk("t4 sram0", int'(sram[0]), 5);
    chk("t4 sram1", int'(sram[1]), 6);

    // Reset during RESP of an rq0 read: no ack, outputs idle, prio back to 0.
    drive(0, 1'b1, 1'b0, 3, 0);
    step(); step();
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 3, 0);
    @(negedge clk);
    chk("t5 ack0 in rst", int'(bus.rq0_ack), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5 busy", int'(bus.busy), 0);
    chk("t5 ack0", int'(bus.rq0_ack), 0);
    chk("t5 rdata0", int'(bus.rq0_rdata), 0);
    chk("t5 mem_cs", int'(bus.mem_cs), 0);
    step();
    do_pair(0, 2, c0, c1, r0, r1);
    chk("t5 ack0 first", c0, 2);
    chk("t5 ack1 second", c1, 5);

    // Back-to-back on rq0 with req held through the first ack.
    step();
    drive(0, 1'b1, 1'b0, 2, 0);
    a1 = -1; a2 = -1; rd2 = -1;
    for (int i = 0; i < 6 && a1 < 0; i++) begin
      @(negedge clk);
      if (bus.rq0_ack) a1 = cyc;
    end
    @(negedge clk);
    chk("t6 idle gap busy", int'(bus.busy), 0);
    for (int i = 0; i < 6 && a2 < 0; i++) begin
      @(negedge clk);
      if (bus.rq0_ack) begin a2 = cyc; rd2 = int'(bus.rq0_rdata); end
    end
    step();
    drive(0, 1'b0, 1'b0, 2, 0);
    chk("t6 ack spacing", a2 - a1, 3);
    chk("t6 rdata", rd2, 10);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end
endmodule
